// File: rtl/ins_loader_if.sv
// Byte-stream, control and imem-write signals of the instruction loader.
// Combinational bundle only; no latency of its own.
// Backpressure is in_ready from the loader toward the byte source.
interface ins_loader_if #(
    parameter int DATA_WIDTH = 32,
    parameter int BUS_WIDTH  = 10
);
    logic                  start;
    logic [BUS_WIDTH:0]    word_count;
    logic                  in_valid;
    logic [7:0]            in_data;
    logic                  in_ready;
    logic                  imem_we;
    logic [BUS_WIDTH-1:0]  imem_waddr;
    logic [DATA_WIDTH-1:0] imem_wdata;
    logic                  cpu_halt;
    logic                  busy;
    logic                  done;
    logic                  err;

    // Host / byte source side.
    modport master (
        output start, word_count, in_valid, in_data,
        input  in_ready, imem_we, imem_waddr, imem_wdata, cpu_halt, busy, done, err
    );

    // Loader side.
    modport slave (
        input  start, word_count, in_valid, in_data,
        output in_ready, imem_we, imem_waddr, imem_wdata, cpu_halt, busy, done, err
    );
endinterface

// File: rtl/ins_loader.sv
// Streams bytes into big-endian DATA_WIDTH words and writes them to imem from address 0, CPU halted meanwhile.
// Last byte in cycle N -> imem_we in N+1 -> done in N+2; bad word_count -> done/err the cycle after start.
// in_ready is high only in RECV (and CHK); the loader stalls indefinitely while in_valid is low.
// Optional: define CHECKSUM_EN to require a trailing mod-256 sum byte after the last word.
module ins_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int BUS_WIDTH  = 10
) (
    input logic         clk,
    input logic         rst,
    ins_loader_if.slave io
);
    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int BCW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    localparam logic [BCW-1:0]       LAST_BYTE = BCW'(NBYTES - 1);
    localparam logic [BCW-1:0]       BYTE_ONE  = BCW'(1);
    localparam logic [BUS_WIDTH-1:0] IDX_ONE   = BUS_WIDTH'(1);
    localparam logic [BUS_WIDTH:0]   WC_ONE    = (BUS_WIDTH + 1)'(1);
    localparam logic [BUS_WIDTH:0]   MAX_WORDS = {1'b1, {BUS_WIDTH{1'b0}}};

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RECV  = 3'd1,
        WRITE = 3'd2,
`ifdef CHECKSUM_EN
        CHK   = 3'd3,
`endif
        FIN   = 3'd4
    } state_t;

    state_t                state;
    logic [BCW-1:0]        byte_cnt;
    logic [BUS_WIDTH-1:0]  index;
    logic [BUS_WIDTH-1:0]  last_idx;
    logic [DATA_WIDTH-1:0] shreg;
    logic [DATA_WIDTH-1:0] shifted;
    logic                  take;
`ifdef CHECKSUM_EN
    logic [7:0]            sum;
`endif

    // Incoming byte enters at the LSB, so the first byte of a word ends up in the top byte.
    assign shifted = DATA_WIDTH'({shreg, io.in_data});
    assign take    = io.in_valid && io.in_ready;

    // Load sequencer; all outputs are registered and updated on state transitions.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            byte_cnt      <= '0;
            index         <= '0;
            last_idx      <= '0;
            shreg         <= '0;
            io.in_ready   <= 1'b0;
            io.imem_we    <= 1'b0;
            io.imem_waddr <= '0;
            io.imem_wdata <= '0;
            io.cpu_halt   <= 1'b0;
            io.busy       <= 1'b0;
            io.done       <= 1'b0;
            io.err        <= 1'b0;
`ifdef CHECKSUM_EN
            sum           <= '0;
`endif
        end else begin
            // Strobes last exactly one cycle unless re-asserted below.
            io.imem_we <= 1'b0;
            io.done    <= 1'b0;
            io.err     <= 1'b0;
            case (state)
                IDLE: begin
                    if (io.start) begin
                        io.busy     <= 1'b1;
                        io.cpu_halt <= 1'b1;
                        if (io.word_count == '0 || io.word_count > MAX_WORDS) begin
                            state   <= FIN;
                            io.done <= 1'b1;
                            io.err  <= 1'b1;
                        end else begin
                            state       <= RECV;
                            last_idx    <= BUS_WIDTH'(io.word_count - WC_ONE);
                            index       <= '0;
                            byte_cnt    <= '0;
                            io.in_ready <= 1'b1;
`ifdef CHECKSUM_EN
                            sum         <= '0;
`endif
                        end
                    end
                end
                RECV: begin
                    if (take) begin
                        shreg <= shifted;
`ifdef CHECKSUM_EN
                        sum   <= sum + io.in_data;
`endif
                        if (byte_cnt == LAST_BYTE) begin
                            byte_cnt      <= '0;
                            state         <= WRITE;
                            io.in_ready   <= 1'b0;
                            io.imem_we    <= 1'b1;
                            io.imem_waddr <= index;
                            io.imem_wdata <= shifted;
                        end else begin
                            byte_cnt <= byte_cnt + BYTE_ONE;
                        end
                    end
                end
                WRITE: begin
                    if (index == last_idx) begin
`ifdef CHECKSUM_EN
                        state       <= CHK;
                        io.in_ready <= 1'b1;
`else
                        state       <= FIN;
                        io.done     <= 1'b1;
`endif
                    end else begin
                        index       <= index + IDX_ONE;
                        state       <= RECV;
                        io.in_ready <= 1'b1;
                    end
                end
`ifdef CHECKSUM_EN
                CHK: begin
                    if (take) begin
                        state       <= FIN;
                        io.in_ready <= 1'b0;
                        io.done     <= 1'b1;
                        io.err      <= (io.in_data != sum);
                    end
                end
`endif
                FIN: begin
                    state       <= IDLE;
                    io.busy     <= 1'b0;
                    io.cpu_halt <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ins_loader.sv
// Self-checking bench for ins_loader: a scoreboard of expected imem writes and done/err pulses.
// Small BUS_WIDTH so a full-capacity load stays short.
// Byte source holds in_valid until in_ready is seen, optionally idling a cycle between bytes.
module tb_ins_loader;
    localparam int DW = 32;
    localparam int BW = 4;

    typedef struct {
        logic [BW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ins_loader_if #(.DATA_WIDTH(DW), .BUS_WIDTH(BW)) io ();
    ins_loader #(.DATA_WIDTH(DW), .BUS_WIDTH(BW)) dut (.clk(clk), .rst(rst), .io(io.slave));

    int      n_checks = 0;
    int      n_errors = 0;
    int      cyc = 0;
    int      last_acc_cyc = 0;
    int      done_cyc = 0;
    int      done_cnt = 0;
    bit      prev_done = 1'b0;
    wr_t     exp_wr[$];
    bit      exp_err[$];
    wr_t     e;
    logic [DW-1:0] wq[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: pops the scoreboard on every imem write and every done pulse.
    always @(negedge clk) begin
        if (io.imem_we) begin
            check("rdy_in_write", io.in_ready, 0);
            check("wr_lat", cyc - last_acc_cyc, 1);
            if (exp_wr.size() == 0) check("unexp_write", 1, 0);
            else begin
                e = exp_wr.pop_front();
                check("waddr", io.imem_waddr, e.addr);
                check("wdata", io.imem_wdata, e.data);
            end
        end
        if (io.in_valid && io.in_ready) last_acc_cyc = cyc;
        if (io.done) begin
            if (exp_err.size() == 0) check("unexp_done", 1, 0);
            else check("done_err", io.err, exp_err.pop_front());
            check("halt_at_done", io.cpu_halt, 1);
            done_cnt++;
            done_cyc = cyc;
            prev_done = 1'b1;
        end else if (prev_done) begin
            check("halt_after_done", io.cpu_halt, 0);
            check("busy_after_done", io.busy, 0);
            prev_done = 1'b0;
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_rdy"}, io.in_ready, 0);
        check({tag, "_we"}, io.imem_we, 0);
        check({tag, "_addr"}, io.imem_waddr, 0);
        check({tag, "_data"}, io.imem_wdata, 0);
        check({tag, "_halt"}, io.cpu_halt, 0);
        check({tag, "_busy"}, io.busy, 0);
        check({tag, "_done"}, io.done, 0);
        check({tag, "_err"}, io.err, 0);
    endtask

    // Called at a negedge; returns at the negedge following the accepting posedge.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        io.in_valid = 1'b1;
        io.in_data  = b;
        while (!io.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("rdy_timeout", 0, 1);
        check("halt_mid", io.cpu_halt, 1);
        @(negedge clk);
        io.in_valid = 1'b0;
    endtask

    task automatic wait_done(input int tgt, input int lim, input string tag);
        for (int n = 0; n < lim && done_cnt < tgt; n++) @(negedge clk);
        check(tag, done_cnt >= tgt, 1);
        #1;
    endtask

    // Loads the words in wq; optional idle cycle between bytes, bad checksum, and a stray start mid-load.
    task automatic load(input bit toggle, input bit bad_chk, input bit poke);
        int         tgt = done_cnt + 1;
        logic [7:0] sum = 8'h00;
        logic [7:0] b;
        logic [DW-1:0] w;
        for (int i = 0; i < wq.size(); i++) exp_wr.push_back('{addr: BW'(i), data: wq[i]});
`ifdef CHECKSUM_EN
        exp_err.push_back(bad_chk);
`else
        exp_err.push_back(1'b0);
`endif
        @(negedge clk);
        io.word_count = (BW + 1)'(wq.size());
        io.start = 1'b1;
        @(negedge clk);
        io.start = 1'b0;
        check("halt_after_start", io.cpu_halt, 1);
        check("busy_after_start", io.busy, 1);
        for (int i = 0; i < wq.size(); i++) begin
            w = wq[i];
            for (int k = DW / 8 - 1; k >= 0; k--) begin
                b = w[8*k +: 8];
                sum = sum + b;
                send_byte(b);
                if (toggle) @(negedge clk);
                if (poke && i == 0 && k == DW / 8 - 1) begin
                    io.word_count = '0;
                    io.start = 1'b1;
                    @(negedge clk);
                    io.start = 1'b0;
                end
            end
        end
`ifdef CHECKSUM_EN
        send_byte(bad_chk ? sum + 8'h01 : sum);
`endif
        wait_done(tgt, 20, "load_done");
    endtask

    task automatic bad_start(input logic [BW:0] wc);
        int tgt = done_cnt + 1;
        exp_err.push_back(1'b1);
        @(negedge clk);
        io.word_count = wc;
        io.start = 1'b1;
        @(negedge clk);
        io.start = 1'b0;
        check("bad_rdy", io.in_ready, 0);
        wait_done(tgt, 2, "bad_done");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        io.start = 1'b0;
        io.word_count = '0;
        io.in_valid = 1'b0;
        io.in_data = 8'h00;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // Single word, then done latency relative to the last accepted byte.
        wq = '{32'h20110001};
        load(1'b0, 1'b0, 1'b0);
`ifdef CHECKSUM_EN
        check("done_lat", done_cyc - last_acc_cyc, 1);
`else
        check("done_lat", done_cyc - last_acc_cyc, 2);
`endif

        // Three words with in_valid toggling every other cycle.
        wq = '{32'h08000c05, 32'h20110001, 32'h20120002};
        load(1'b1, 1'b0, 1'b0);

        // Out-of-range word counts.
        bad_start('0);
        bad_start((BW + 1)'((1 << BW) + 1));

        // Full capacity load: last address is 2**BW-1.
        wq.delete();
        for (int i = 0; i < (1 << BW); i++) wq.push_back($urandom);
        load(1'b0, 1'b0, 1'b0);

        // Reset after two bytes of the second word.
        exp_wr.push_back('{addr: '0, data: 32'hdeadbeef});
        @(negedge clk);
        io.word_count = (BW + 1)'(2);
        io.start = 1'b1;
        @(negedge clk);
        io.start = 1'b0;
        send_byte(8'hde); send_byte(8'had); send_byte(8'hbe); send_byte(8'hef);
        send_byte(8'h11); send_byte(8'h22);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("midrst");
        rst = 1'b0;
        check("midrst_wrq", exp_wr.size(), 0);

        // Fresh load after reset, with a stray start while busy.
        wq = '{32'h20110001};
        load(1'b0, 1'b0, 1'b1);

`ifdef CHECKSUM_EN
        // Wrong checksum: word still written, done with err.
        wq = '{32'h20110001};
        load(1'b0, 1'b1, 1'b0);
`endif

        repeat (3) @(negedge clk);
        check("final_wr_q", exp_wr.size(), 0);
        check("final_done_q", exp_err.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
